two_way_demux: RTL
==================

// Module: two_way_demux
// PURPOSE
//  Registered 1-to-2 stream demultiplexer: the distribution end of the two-way select path.
//  Routes one valid/ready input stream to one of two output streams, y0 or y1.
//  The route is chosen by s_sel on the first beat of a packet.
//  The route stays locked until the beat carrying s_last has been accepted.
//  Sits between a single producer and two consumers.
// PARAMETERS
//  DATA_W     8    payload width in bits
//  CNT_W      16   beat-counter width (used only with DEMUX_BEAT_CNT_EN)
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  s_data     in   DATA_W   input payload
//  s_sel      in   1        route select: 0 -> y0, 1 -> y1; sampled on the first beat only
//  s_last     in   1        final beat of the packet
//  s_valid    in   1        input beat valid
//  s_ready    out  1        input beat accepted when s_valid && s_ready
//  y0_data    out  DATA_W   output 0 payload
//  y0_last    out  1        output 0 last
//  y0_valid   out  1        output 0 valid
//  y0_ready   in   1        output 0 ready
//  y1_data    out  DATA_W   output 1 payload
//  y1_last    out  1        output 1 last
//  y1_valid   out  1        output 1 valid
//  y1_ready   in   1        output 1 ready
//  y0_beats   out  CNT_W    beats delivered on y0 (only with DEMUX_BEAT_CNT_EN)
//  y1_beats   out  CNT_W    beats delivered on y1 (only with DEMUX_BEAT_CNT_EN)
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; yN_valid=0, yN_data=0, yN_last=0, yN_beats=0.
//   - s_ready=0 while rst_n=0.
//  FSM states: IDLE, LOCK0, LOCK1.
//   - IDLE: target = s_sel.
//   - LOCKn: target = n; s_sel is ignored.
//   - IDLE, beat accepted with s_last=0: go to LOCK{s_sel}.
//   - IDLE, beat accepted with s_last=1: stay in IDLE (single-beat packet).
//   - LOCKn, beat accepted with s_last=1: go to IDLE.
//   - No accepted beat: state holds.
//  Output slices:
//   - Each output has a one-entry register slice.
//   - slot_free(n) = !yN_valid || yN_ready.
//   - s_ready = rst_n && slot_free(target). Combinational from state, s_sel and yN_valid/yN_ready.
//   - s_ready never depends on s_valid.
//  Latency: an accepted beat appears on yN_* on the next clock edge (1 cycle).
//   - Full throughput of 1 beat/cycle while yN_ready=1.
//  Stall rules:
//   - While yN_valid && !yN_ready, yN_data and yN_last hold stable.
//   - yN_valid falls only after a handshake with no new beat loaded in the same cycle.
//  Non-target output:
//   - Never blocks the input.
//   - Drains independently (a stalled y1 does not stall a packet to y0).
//  Simultaneous events: in the same cycle, yN drains and a new beat loads into yN
//   - yN_valid stays 1 and the data is replaced.
//  Reset mid-packet:
//   - Slices are cleared and in-flight beats are discarded.
//   - State returns to IDLE; the next first beat's s_sel is honoured.
// CONFIGURATION
//  Macro DEMUX_BEAT_CNT_EN:
//   - Defined: y0_beats/y1_beats exist. Each increments by 1 on every yN_valid && yN_ready.
//     Wraps modulo 2^CNT_W. Reset to 0.
//   - Undefined: both ports and their counters are absent. All other behaviour is identical.
// STRUCTURE
//  Package two_way_demux_pkg:
//   - State encoding localparams: ST_IDLE=2'd0, ST_LOCK0=2'd1, ST_LOCK1=2'd2.
//   - Default DATA_W and CNT_W.
//  Sub-module demux_out_slice (params DATA_W, CNT_W):
//   - One-entry register slice: load/valid/ready plus the optional beat counter.
//   - Instantiated twice, once for y0 and once for y1.
//  Top level: FSM, target decode, s_ready logic.
// TESTING
//  1. Single-beat packet, s_sel=0, s_data=8'hA5, s_last=1, y0_ready=1:
//     -> y0_valid=1 with y0_data=A5, y0_last=1 next cycle; y1_valid stays 0; state=IDLE.
//  2. 3-beat packet 8'h11/22/33, s_sel=1 on beat 1, s_sel=0 on beats 2-3:
//     -> all three beats on y1 in order; y0_valid never 1.
//  3. y0_ready=0, two beats to y0:
//     -> first beat held on y0; s_ready=0.
//     -> raise y0_ready: second beat appears next cycle; no loss, no duplication.
//  4. y1_ready=0 with y1_valid=1, then a 4-beat packet to y0 with y0_ready=1:
//     -> s_ready=1 throughout; y1_data unchanged.
//  5. rst_n asserted low after beat 2 of a 4-beat LOCK1 packet:
//     -> valids=0 immediately; new packet with s_sel=0 after release goes to y0.
//  6. With DEMUX_BEAT_CNT_EN, 5 beats to y0 and 3 beats to y1:
//     -> y0_beats=5, y1_beats=3; CNT_W=2 check: y0_beats wraps to 1.

Source files
------------

// File: rtl/two_way_demux_pkg.sv
// Shared types and defaults for the two-way stream demultiplexer.
// The optional per-output beat counters are enabled with DEMUX_BEAT_CNT_EN.
package two_way_demux_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_LOCK0 = ST_LOCK0,
        S_LOCK1 = ST_LOCK1
    } state_t;

    function automatic state_t lock_of(input logic sel);
        return sel ? S_LOCK1 : S_LOCK0;
    endfunction

endpackage

// File: rtl/two_way_demux_out_slice.sv
// One-entry output register slice for one branch of the demux (module demux_out_slice).
// With DEMUX_BEAT_CNT_EN defined it also counts delivered beats, wrapping at 2^CNT_W.
module demux_out_slice #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              slot_free,
    output logic [DATA_W-1:0] y_data,
    output logic              y_last,
    output logic              y_valid,
`ifdef DEMUX_BEAT_CNT_EN
    output logic [CNT_W-1:0]  y_beats,
`endif
    input  logic              y_ready
);

    assign slot_free = !y_valid || y_ready;

    // A load in the same cycle as a drain keeps valid high and replaces the payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            y_last  <= 1'b0;
        end else if (load) begin
            y_valid <= 1'b1;
            y_data  <= in_data;
            y_last  <= in_last;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

`ifdef DEMUX_BEAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_beats <= '0;
        end else if (y_valid && y_ready) begin
            y_beats <= y_beats + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/two_way_demux.sv
// Registered 1-to-2 valid/ready demultiplexer; the route is picked by s_sel on a packet's
// first beat and held until s_last is accepted. DEMUX_BEAT_CNT_EN adds y0_beats/y1_beats.
//
// state | meaning
// IDLE  | between packets; the next beat's s_sel picks the route
// LOCK0 | mid-packet, routed to y0
// LOCK1 | mid-packet, routed to y1
module two_way_demux
    import two_way_demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sel,
    input  logic              s_last,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] y0_data,
    output logic              y0_last,
    output logic              y0_valid,
    input  logic              y0_ready,
    output logic [DATA_W-1:0] y1_data,
    output logic              y1_last,
    output logic              y1_valid,
`ifdef DEMUX_BEAT_CNT_EN
    output logic [CNT_W-1:0]  y0_beats,
    output logic [CNT_W-1:0]  y1_beats,
`endif
    input  logic              y1_ready
);

    state_t state, state_nx;
    logic   target;
    logic   free0, free1;
    logic   accept;
    logic   load0, load1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        target = s_sel;
        case (state)
            S_LOCK0: target = 1'b0;
            S_LOCK1: target = 1'b1;
            default: target = s_sel;
        endcase
    end

    // Only the targeted slice gates the input; the other one drains on its own.
    assign s_ready = rst_n && (target ? free1 : free0);
    assign accept  = s_valid && s_ready;
    assign load0   = accept && !target;
    assign load1   = accept && target;

    always_comb begin
        state_nx = state;
        if (accept) begin
            case (state)
                S_IDLE:  if (!s_last) state_nx = lock_of(s_sel);
                S_LOCK0,
                S_LOCK1: if (s_last) state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    demux_out_slice #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slice0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load0),
        .in_data   (s_data),
        .in_last   (s_last),
        .slot_free (free0),
        .y_data    (y0_data),
        .y_last    (y0_last),
        .y_valid   (y0_valid),
`ifdef DEMUX_BEAT_CNT_EN
        .y_beats   (y0_beats),
`endif
        .y_ready   (y0_ready)
    );

    demux_out_slice #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slice1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load1),
        .in_data   (s_data),
        .in_last   (s_last),
        .slot_free (free1),
        .y_data    (y1_data),
        .y_last    (y1_last),
        .y_valid   (y1_valid),
`ifdef DEMUX_BEAT_CNT_EN
        .y_beats   (y1_beats),
`endif
        .y_ready   (y1_ready)
    );

endmodule
